// File: rtl/uart_core_fifo.sv
// UART core with TX and RX FIFOs behind a cs/addr/wdata/we/rdata register port.
// Configurable data width, parity (off/even/odd), 1 or 2 stop bits, runtime
// baud divisor, sticky error flags and a level interrupt.
//
// Ports:
//   clk    - single clock, all logic on posedge
//   rst_n  - synchronous active-low reset
//   cs     - register access strobe
//   addr   - byte address (0x00 DATA, 0x04 STATUS, 0x08 CTRL, 0x0C BAUD_DIV)
//   wdata  - write data
//   we     - 1 = write, 0 = read (qualified by cs)
//   rdata  - registered read data, holds until the next read
//   tx     - serial output, idle high
//   rx     - asynchronous serial input
//   irq    - registered level interrupt
module uart_core_fifo #(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned FIFO_DEPTH  = 16,
  parameter int unsigned DEFAULT_DIV = 867
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cs,
  input  logic [7:0]  addr,
  input  logic [31:0] wdata,
  input  logic        we,
  output logic [31:0] rdata,
  output logic        tx,
  input  logic        rx,
  output logic        irq
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam int unsigned BitW = $clog2(DATA_W);
  localparam logic [CntW-1:0] FullCnt = CntW'(FIFO_DEPTH);
  localparam logic [BitW-1:0] LastBit = BitW'(DATA_W - 1);

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

  // Bus decode
  logic rd_any, wr_data, rd_data, wr_status, wr_ctrl, wr_baud;
  assign rd_any    = cs && !we;
  assign rd_data   = rd_any && (addr == 8'h00);
  assign wr_data   = cs && we && (addr == 8'h00);
  assign wr_status = cs && we && (addr == 8'h04);
  assign wr_ctrl   = cs && we && (addr == 8'h08);
  assign wr_baud   = cs && we && (addr == 8'h0C);

  logic unused_wdata;
  assign unused_wdata = ^wdata[31:16];

  // Control and status registers
  logic [5:0]  ctrl_q;
  logic [15:0] baud_q;
  logic        ov_q, pe_q, fe_q;
  logic [31:0] rdata_q, rdata_d;
  logic        irq_q, irq_d;
  logic        set_ov, set_pe, set_fe;

  // TX FIFO
  logic [DATA_W-1:0] txf_mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]   txf_wptr_q, txf_rptr_q;
  logic [CntW-1:0]   txf_cnt_q, txf_cnt_d;
  logic              txf_full, txf_empty, txf_push, txf_pop;
  logic [DATA_W-1:0] txf_head;

  assign txf_full  = (txf_cnt_q == FullCnt);
  assign txf_empty = (txf_cnt_q == '0);
  assign txf_head  = txf_mem_q[txf_rptr_q];
  // A push into a full FIFO is accepted only when a pop frees a slot the same cycle.
  assign txf_push  = wr_data && (!txf_full || txf_pop);

  // RX FIFO
  logic [DATA_W-1:0] rxf_mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]   rxf_wptr_q, rxf_rptr_q;
  logic [CntW-1:0]   rxf_cnt_q, rxf_cnt_d;
  logic              rxf_full, rxf_empty, rxf_push, rxf_pop, rx_word_valid;
  logic [DATA_W-1:0] rx_word;

  assign rxf_full  = (rxf_cnt_q == FullCnt);
  assign rxf_empty = (rxf_cnt_q == '0);
  assign rxf_pop   = rd_data && !rxf_empty;
  assign rxf_push  = rx_word_valid && (!rxf_full || rxf_pop);
  assign set_ov    = rx_word_valid && rxf_full && !rxf_pop;

  always_comb begin
    txf_cnt_d = txf_cnt_q;
    if (txf_push && !txf_pop) txf_cnt_d = txf_cnt_q + 1'b1;
    else if (!txf_push && txf_pop) txf_cnt_d = txf_cnt_q - 1'b1;
    rxf_cnt_d = rxf_cnt_q;
    if (rxf_push && !rxf_pop) rxf_cnt_d = rxf_cnt_q + 1'b1;
    else if (!rxf_push && rxf_pop) rxf_cnt_d = rxf_cnt_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (txf_push) txf_mem_q[txf_wptr_q] <= wdata[DATA_W-1:0];
    if (rxf_push) rxf_mem_q[rxf_wptr_q] <= rx_word;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      txf_wptr_q <= '0;
      txf_rptr_q <= '0;
      txf_cnt_q  <= '0;
      rxf_wptr_q <= '0;
      rxf_rptr_q <= '0;
      rxf_cnt_q  <= '0;
    end else begin
      if (txf_push) txf_wptr_q <= txf_wptr_q + 1'b1;
      if (txf_pop)  txf_rptr_q <= txf_rptr_q + 1'b1;
      if (rxf_push) rxf_wptr_q <= rxf_wptr_q + 1'b1;
      if (rxf_pop)  rxf_rptr_q <= rxf_rptr_q + 1'b1;
      txf_cnt_q <= txf_cnt_d;
      rxf_cnt_q <= rxf_cnt_d;
    end
  end

  // TX FSM. Frame settings and divisor are captured at frame start.
  state_e            tx_state_q, tx_state_d;
  logic [15:0]       tx_cnt_q, tx_cnt_d, tx_div_q, tx_div_d;
  logic [DATA_W-1:0] tx_shift_q, tx_shift_d;
  logic [BitW-1:0]   tx_bit_q, tx_bit_d;
  logic              tx_par_q, tx_par_d, tx_paren_q, tx_paren_d, tx_two_q, tx_two_d;
  logic              tx_q, tx_d, tx_start, tx_tick, tx_busy;

  assign tx_tick = (tx_cnt_q == '0);
  assign tx_busy = (tx_state_q != StIdle);

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_tick ? tx_div_q : tx_cnt_q - 16'd1;
    tx_div_d   = tx_div_q;
    tx_shift_d = tx_shift_q;
    tx_bit_d   = tx_bit_q;
    tx_par_d   = tx_par_q;
    tx_paren_d = tx_paren_q;
    tx_two_d   = tx_two_q;
    tx_start   = 1'b0;
    unique case (tx_state_q)
      StIdle: begin
        tx_cnt_d = tx_cnt_q;
        tx_start = ctrl_q[0] && !txf_empty;
      end
      StStart: if (tx_tick) begin
        tx_state_d = StData;
        tx_bit_d   = '0;
      end
      StData: if (tx_tick) begin
        tx_shift_d = tx_shift_q >> 1;
        if (tx_bit_q == LastBit) begin
          tx_state_d = tx_paren_q ? StParity : StStop;
          tx_bit_d   = '0;
        end else begin
          tx_bit_d = tx_bit_q + 1'b1;
        end
      end
      StParity: if (tx_tick) tx_state_d = StStop;
      StStop: if (tx_tick) begin
        if (tx_two_q && (tx_bit_q == '0)) tx_bit_d = BitW'(1);
        else if (ctrl_q[0] && !txf_empty) tx_start = 1'b1;
        else tx_state_d = StIdle;
      end
      default: tx_state_d = StIdle;
    endcase
    if (tx_start) begin
      tx_state_d = StStart;
      tx_cnt_d   = baud_q;
      tx_div_d   = baud_q;
      tx_shift_d = txf_head;
      tx_par_d   = (^txf_head) ^ ctrl_q[3];
      tx_paren_d = ctrl_q[2];
      tx_two_d   = ctrl_q[4];
      tx_bit_d   = '0;
    end
    // tx is registered from the next-state view so it never glitches.
    unique case (tx_state_d)
      StStart:  tx_d = 1'b0;
      StData:   tx_d = tx_shift_d[0];
      StParity: tx_d = tx_par_d;
      default:  tx_d = 1'b1;
    endcase
  end

  assign txf_pop = tx_start;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_state_q <= StIdle;
      tx_cnt_q   <= '0;
      tx_div_q   <= '0;
      tx_shift_q <= '0;
      tx_bit_q   <= '0;
      tx_par_q   <= 1'b0;
      tx_paren_q <= 1'b0;
      tx_two_q   <= 1'b0;
      tx_q       <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_div_q   <= tx_div_d;
      tx_shift_q <= tx_shift_d;
      tx_bit_q   <= tx_bit_d;
      tx_par_q   <= tx_par_d;
      tx_paren_q <= tx_paren_d;
      tx_two_q   <= tx_two_d;
      tx_q       <= tx_d;
    end
  end

  // RX path: two-flop synchroniser plus one history flop for edge detection.
  logic              rx_s1_q, rx_s2_q, rx_s3_q, rx_fall;
  state_e            rx_state_q, rx_state_d;
  logic [15:0]       rx_cnt_q, rx_cnt_d, rx_div_q, rx_div_d;
  logic [DATA_W-1:0] rx_shift_q, rx_shift_d;
  logic [BitW-1:0]   rx_bit_q, rx_bit_d;
  logic              rx_paren_q, rx_paren_d, rx_parodd_q, rx_parodd_d;
  logic              rx_perr_q, rx_perr_d, rx_tick;

  assign rx_fall = rx_s3_q && !rx_s2_q;
  assign rx_tick = (rx_cnt_q == '0);
  assign rx_word = rx_shift_q;

  always_comb begin
    rx_state_d    = rx_state_q;
    rx_cnt_d      = rx_tick ? rx_div_q : rx_cnt_q - 16'd1;
    rx_div_d      = rx_div_q;
    rx_shift_d    = rx_shift_q;
    rx_bit_d      = rx_bit_q;
    rx_paren_d    = rx_paren_q;
    rx_parodd_d   = rx_parodd_q;
    rx_perr_d     = rx_perr_q;
    rx_word_valid = 1'b0;
    set_pe        = 1'b0;
    set_fe        = 1'b0;
    unique case (rx_state_q)
      StIdle: begin
        rx_cnt_d = rx_cnt_q;
        if (ctrl_q[1] && rx_fall) begin
          rx_state_d  = StStart;
          rx_div_d    = baud_q;
          rx_cnt_d    = baud_q >> 1;  // first sample lands mid start bit
          rx_paren_d  = ctrl_q[2];
          rx_parodd_d = ctrl_q[3];
          rx_perr_d   = 1'b0;
        end
      end
      StStart: if (rx_tick) begin
        rx_state_d = rx_s2_q ? StIdle : StData;
        rx_bit_d   = '0;
      end
      StData: if (rx_tick) begin
        rx_shift_d = {rx_s2_q, rx_shift_q[DATA_W-1:1]};
        if (rx_bit_q == LastBit) rx_state_d = rx_paren_q ? StParity : StStop;
        else rx_bit_d = rx_bit_q + 1'b1;
      end
      StParity: if (rx_tick) begin
        rx_perr_d  = ((^rx_shift_q) ^ rx_parodd_q) != rx_s2_q;
        rx_state_d = StStop;
      end
      StStop: if (rx_tick) begin
        // Only the first stop bit is checked; IDLE then waits for the next edge.
        rx_state_d = StIdle;
        if (!rx_s2_q) begin
          set_fe = 1'b1;
        end else begin
          rx_word_valid = 1'b1;
          set_pe        = rx_perr_q;
        end
      end
      default: rx_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_s1_q     <= 1'b1;
      rx_s2_q     <= 1'b1;
      rx_s3_q     <= 1'b1;
      rx_state_q  <= StIdle;
      rx_cnt_q    <= '0;
      rx_div_q    <= '0;
      rx_shift_q  <= '0;
      rx_bit_q    <= '0;
      rx_paren_q  <= 1'b0;
      rx_parodd_q <= 1'b0;
      rx_perr_q   <= 1'b0;
    end else begin
      rx_s1_q     <= rx;
      rx_s2_q     <= rx_s1_q;
      rx_s3_q     <= rx_s2_q;
      rx_state_q  <= rx_state_d;
      rx_cnt_q    <= rx_cnt_d;
      rx_div_q    <= rx_div_d;
      rx_shift_q  <= rx_shift_d;
      rx_bit_q    <= rx_bit_d;
      rx_paren_q  <= rx_paren_d;
      rx_parodd_q <= rx_parodd_d;
      rx_perr_q   <= rx_perr_d;
    end
  end

  // Register file, read mux and interrupt
  logic [31:0] status;
  assign status = {24'b0, tx_busy, fe_q, pe_q, ov_q, rxf_empty, rxf_full, txf_empty, txf_full};

  always_comb begin
    rdata_d = rdata_q;
    if (rd_any) begin
      unique case (addr)
        8'h00:   rdata_d = rxf_empty ? 32'b0 : 32'(rxf_mem_q[rxf_rptr_q]);
        8'h04:   rdata_d = status;
        8'h08:   rdata_d = {26'b0, ctrl_q};
        8'h0C:   rdata_d = {16'b0, baud_q};
        default: rdata_d = 32'b0;
      endcase
    end
    irq_d = ctrl_q[5] && (!rxf_empty || ov_q || pe_q || fe_q);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ctrl_q  <= '0;
      baud_q  <= 16'(DEFAULT_DIV);
      ov_q    <= 1'b0;
      pe_q    <= 1'b0;
      fe_q    <= 1'b0;
      rdata_q <= '0;
      irq_q   <= 1'b0;
    end else begin
      if (wr_ctrl) ctrl_q <= wdata[5:0];
      if (wr_baud) baud_q <= wdata[15:0];
      // Set wins over a same-cycle W1C clear.
      ov_q    <= (ov_q && !(wr_status && wdata[4])) || set_ov;
      pe_q    <= (pe_q && !(wr_status && wdata[5])) || set_pe;
      fe_q    <= (fe_q && !(wr_status && wdata[6])) || set_fe;
      rdata_q <= rdata_d;
      irq_q   <= irq_d;
    end
  end

  assign rdata = rdata_q;
  assign tx    = tx_q;
  assign irq   = irq_q;

endmodule

// File: tb/tb_uart_core_fifo.sv
// Self-checking bench for uart_core_fifo: serial waveforms and received words are
// predicted from frame rules (bit lists, a queue-based RX FIFO) built in the bench.
module tb_uart_core_fifo;
  localparam int Depth = 4;

  logic        clk = 1'b0, rst_n = 1'b0, cs = 1'b0, we = 1'b0;
  logic [7:0]  addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        tx, irq, rx;
  logic        rx_drv = 1'b1, loop_en = 1'b0;
  int          errors = 0, checks = 0;

  assign rx = loop_en ? tx : rx_drv;
  always #5 clk = ~clk;

  uart_core_fifo #(.DATA_W(8), .FIFO_DEPTH(Depth), .DEFAULT_DIV(867)) dut (
    .clk(clk), .rst_n(rst_n), .cs(cs), .addr(addr), .wdata(wdata), .we(we),
    .rdata(rdata), .tx(tx), .rx(rx), .irq(irq)
  );

  function automatic logic [31:0] mk_status(bit txf, bit txe, bit rxf, bit rxe, bit ov,
                                            bit pe, bit fe, bit busy);
    return {24'b0, busy, fe, pe, ov, rxe, rxf, txe, txf};
  endfunction

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_write(input logic [7:0] a, input logic [31:0] d);
    cs = 1'b1; we = 1'b1; addr = a; wdata = d;
    @(posedge clk);
    @(negedge clk);
    cs = 1'b0; we = 1'b0;
  endtask

  task automatic bus_read(input logic [7:0] a, output logic [31:0] d);
    cs = 1'b1; we = 1'b0; addr = a;
    @(posedge clk);
    @(negedge clk);
    cs = 1'b0;
    d = rdata;
  endtask

  // Expected serial bit list for one frame.
  task automatic build_frame(input logic [7:0] d, input bit pe, input bit po, input bit ts,
                             output logic [11:0] bits, output int n);
    bits = '1;
    n = 0;
    bits[n] = 1'b0; n++;
    for (int i = 0; i < 8; i++) begin bits[n] = d[i]; n++; end
    if (pe) begin bits[n] = (^d) ^ po; n++; end
    bits[n] = 1'b1; n++;
    if (ts) begin bits[n] = 1'b1; n++; end
  endtask

  task automatic check_tx_frame(input logic [7:0] d, input bit pe, input bit po, input bit ts,
                                input int div, input string nm);
    logic [11:0] bits;
    int n, w;
    build_frame(d, pe, po, ts, bits, n);
    w = 0;
    while (tx !== 1'b0 && w < 40) begin @(negedge clk); w++; end
    checks++;
    if (tx !== 1'b0) begin
      errors++;
      $display("FAIL %s start: tx=%b after %0d clks, required 0", nm, tx, w);
      return;
    end
    for (int k = 0; k < n * (div + 1); k++) begin
      if (k > 0) @(negedge clk);
      checks++;
      if (tx !== bits[k / (div + 1)]) begin
        errors++;
        $display("FAIL %s clk %0d: tx=%b required %b", nm, k, tx, bits[k / (div + 1)]);
      end
    end
    @(negedge clk);
  endtask

  task automatic drive_rx(input logic [11:0] bits, input int n, input int div);
    for (int i = 0; i < n; i++) begin
      rx_drv = bits[i];
      repeat (div + 1) @(negedge clk);
    end
    rx_drv = 1'b1;
  endtask

  task automatic expect_reg(input logic [7:0] a, input logic [31:0] exp, input string nm);
    logic [31:0] v;
    bus_read(a, v);
    checks++;
    if (v !== exp) begin
      errors++;
      $display("FAIL %s: read 0x%08h required 0x%08h", nm, v, exp);
    end
  endtask

  task automatic expect_irq(input logic exp, input string nm);
    checks++;
    if (irq !== exp) begin
      errors++;
      $display("FAIL %s: irq=%b required %b", nm, irq, exp);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    idle(2);
    checks++;
    if (tx !== 1'b1 || rdata !== 32'h0 || irq !== 1'b0) begin
      errors++;
      $display("FAIL reset outputs: tx=%b rdata=0x%08h irq=%b required 1/0/0", tx, rdata, irq);
    end
    rst_n = 1'b1;
    idle(1);
    expect_reg(8'h04, mk_status(0, 1, 0, 1, 0, 0, 0, 0), "reset status");
    expect_reg(8'h08, 32'h0, "reset ctrl");
    expect_reg(8'h0C, 32'd867, "reset baud");
    expect_reg(8'h40, 32'h0, "unmapped read");
  endtask

  task automatic test_basic;
    bus_write(8'h0C, 32'd3);
    bus_write(8'h08, 32'h01);
    bus_write(8'h00, 32'hA5);
    check_tx_frame(8'hA5, 0, 0, 0, 3, "8N1 A5");
    expect_reg(8'h04, mk_status(0, 1, 0, 1, 0, 0, 0, 0), "8N1 idle status");
  endtask

  task automatic test_parity;
    bus_write(8'h08, 32'h05);
    bus_write(8'h00, 32'hA5);
    check_tx_frame(8'hA5, 1, 0, 0, 3, "even A5");
    bus_write(8'h08, 32'h0D);
    bus_write(8'h00, 32'hA5);
    check_tx_frame(8'hA5, 1, 1, 0, 3, "odd A5");
    bus_write(8'h08, 32'h11);
    bus_write(8'h00, 32'h5A);
    check_tx_frame(8'h5A, 0, 0, 1, 3, "two stop 5A");
    bus_write(8'h00, 32'h33);
    idle(5);
    expect_reg(8'h04, mk_status(0, 1, 0, 1, 0, 0, 0, 1), "busy mid frame");
    idle(60);
  endtask

  task automatic test_tx_random;
    for (int i = 0; i < 4; i++) begin
      logic [7:0] d;
      bit pe, po, ts;
      int div;
      d = 8'($urandom);
      pe = 1'($urandom); po = 1'($urandom); ts = 1'($urandom);
      div = $urandom_range(4, 1);
      bus_write(8'h0C, 32'(div));
      bus_write(8'h08, {27'b0, ts, po, pe, 2'b01});
      bus_write(8'h00, {24'b0, d});
      check_tx_frame(d, pe, po, ts, div, "random tx");
      idle(2);
    end
  endtask

  task automatic test_loopback;
    logic [7:0] q[$];
    logic [31:0] v;
    q = '{8'h3C, 8'hFF, 8'h00};
    loop_en = 1'b1;
    bus_write(8'h0C, 32'd3);
    bus_write(8'h08, 32'h03);
    foreach (q[i]) bus_write(8'h00, {24'b0, q[i]});
    idle(170);
    while (q.size() > 0) begin
      bus_read(8'h00, v);
      checks++;
      if (v !== {24'b0, q[0]}) begin
        errors++;
        $display("FAIL loopback data: read 0x%08h required 0x%08h", v, {24'b0, q[0]});
      end
      void'(q.pop_front());
    end
    expect_reg(8'h04, mk_status(0, 1, 0, 1, 0, 0, 0, 0), "loopback drained status");
    expect_reg(8'h00, 32'h0, "empty rx read");
  endtask

  task automatic test_overrun;
    logic [7:0] rxq[$];
    bit ov_m;
    logic [31:0] v;
    ov_m = 0;
    for (int i = 0; i < 5; i++) begin
      logic [7:0] d;
      d = 8'($urandom);
      bus_write(8'h00, {24'b0, d});
      if (rxq.size() < Depth) rxq.push_back(d);
      else ov_m = 1;
    end
    idle(260);
    expect_reg(8'h04, mk_status(0, 1, rxq.size() == Depth, rxq.size() == 0, ov_m, 0, 0, 0),
               "overrun status");
    while (rxq.size() > 0) begin
      bus_read(8'h00, v);
      checks++;
      if (v !== {24'b0, rxq[0]}) begin
        errors++;
        $display("FAIL overrun data: read 0x%08h required 0x%08h", v, {24'b0, rxq[0]});
      end
      void'(rxq.pop_front());
    end
    bus_write(8'h04, 32'h10);
    expect_reg(8'h04, mk_status(0, 1, 0, 1, 0, 0, 0, 0), "overrun cleared");
  endtask

  task automatic test_loop_random;
    logic [31:0] v;
    for (int i = 0; i < 5; i++) begin
      logic [7:0] d;
      bit pe, po, ts;
      int div, nbits;
      d = 8'($urandom);
      pe = 1'($urandom); po = 1'($urandom); ts = 1'($urandom);
      div = $urandom_range(5, 2);
      nbits = 10 + int'(pe) + int'(ts);
      bus_write(8'h0C, 32'(div));
      bus_write(8'h08, {27'b0, ts, po, pe, 2'b11});
      bus_write(8'h00, {24'b0, d});
      idle(nbits * (div + 1) + 20);
      bus_read(8'h00, v);
      checks++;
      if (v !== {24'b0, d}) begin
        errors++;
        $display("FAIL random loopback pe=%0d po=%0d ts=%0d: read 0x%08h required 0x%08h",
                 pe, po, ts, v, {24'b0, d});
      end
      expect_reg(8'h04, mk_status(0, 1, 0, 1, 0, 0, 0, 0), "random loopback status");
    end
    loop_en = 1'b0;
  endtask

  task automatic test_rx_errors;
    logic [11:0] bits;
    logic [7:0]  d;
    int n;
    logic [31:0] v;
    d = 8'($urandom);
    bus_write(8'h0C, 32'd3);
    bus_write(8'h08, 32'h26);
    idle(2);
    expect_irq(1'b0, "irq quiet");
    build_frame(d, 1, 0, 0, bits, n);
    bits[9] = ~bits[9];
    drive_rx(bits, n, 3);
    idle(12);
    expect_reg(8'h04, mk_status(0, 1, 0, 0, 0, 1, 0, 0), "parity err status");
    expect_irq(1'b1, "irq on parity err");
    bus_read(8'h00, v);
    checks++;
    if (v !== {24'b0, d}) begin
      errors++;
      $display("FAIL parity err word: read 0x%08h required 0x%08h", v, {24'b0, d});
    end
    bus_write(8'h04, 32'h20);
    idle(2);
    expect_irq(1'b0, "irq after pe clear");
    expect_reg(8'h04, mk_status(0, 1, 0, 1, 0, 0, 0, 0), "pe cleared");

    bus_write(8'h08, 32'h22);
    build_frame(d, 0, 0, 0, bits, n);
    bits[9] = 1'b0;
    bits[10] = 1'b0;
    drive_rx(bits, 11, 3);
    idle(12);
    expect_reg(8'h04, mk_status(0, 1, 0, 1, 0, 0, 1, 0), "frame err status");
    expect_irq(1'b1, "irq on frame err");
    bus_write(8'h08, 32'h02);
    idle(2);
    expect_irq(1'b0, "irq masked");
    bus_write(8'h04, 32'h40);
    expect_reg(8'h04, mk_status(0, 1, 0, 1, 0, 0, 0, 0), "fe cleared");
  endtask

  task automatic test_glitch;
    bus_write(8'h0C, 32'd15);
    bus_write(8'h08, 32'h02);
    idle(2);
    rx_drv = 1'b0;
    idle(1);
    rx_drv = 1'b1;
    idle(60);
    expect_reg(8'h04, mk_status(0, 1, 0, 1, 0, 0, 0, 0), "glitch no word");
  endtask

  task automatic test_reset_mid;
    bus_write(8'h0C, 32'd3);
    bus_write(8'h08, 32'h01);
    bus_write(8'h00, 32'h00);
    idle(10);
    rst_n = 1'b0;
    idle(1);
    rst_n = 1'b1;
    checks++;
    if (tx !== 1'b1) begin
      errors++;
      $display("FAIL reset mid frame tx: tx=%b required 1", tx);
    end
    expect_reg(8'h04, mk_status(0, 1, 0, 1, 0, 0, 0, 0), "mid reset status");
    expect_reg(8'h08, 32'h0, "mid reset ctrl");
    expect_reg(8'h0C, 32'd867, "mid reset baud");
    idle(20);
    checks++;
    if (tx !== 1'b1) begin
      errors++;
      $display("FAIL reset mid frame idle: tx=%b required 1", tx);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity();
    test_tx_random();
    test_loopback();
    bus_write(8'h0C, 32'd3);
    bus_write(8'h08, 32'h03);
    loop_en = 1'b1;
    test_overrun();
    test_loop_random();
    test_rx_errors();
    test_glitch();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
